// File: rtl/pipe_stage_buf.sv
// Pipeline register stage between decode and execute with valid/ready handshake and bubble count.
// Define PIPE_STAGE_SKID_EN for a two-entry (main + skid) buffer with a registered in_ready.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W  = 160,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              en_q, en_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [CNT_W-1:0]  bub_q, bub_d;
  logic              accept, consume;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
`endif

  assign out_valid  = (occ_q != 2'd0);
  assign out_data   = out_valid ? main_q : NOP_VAL;
  assign occupancy  = occ_q;
  assign bubble_cnt = bub_q;
  assign accept     = in_valid && in_ready;
  assign consume    = out_valid && out_ready;

  // en_q keeps the stage closed for the first cycle after reset.
`ifdef PIPE_STAGE_SKID_EN
  assign in_ready = !rst && en_q && (occ_q != 2'd2);
`else
  assign in_ready = !rst && en_q && ((occ_q == 2'd0) || out_ready);
`endif

  always_comb begin
    en_d   = 1'b1;
    occ_d  = occ_q;
    main_d = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d = skid_q;
`endif
    if (flush) begin
      occ_d = 2'd0;
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      case (occ_q)
        2'd0: begin
          if (accept) begin
            main_d = in_data;
            occ_d  = 2'd1;
          end
        end
        2'd1: begin
          if (consume && accept) begin
            main_d = in_data;
          end else if (consume) begin
            occ_d = 2'd0;
          end else if (accept) begin
            skid_d = in_data;
            occ_d  = 2'd2;
          end
        end
        default: begin
          if (consume) begin
            main_d = skid_q;
            occ_d  = 2'd1;
          end
        end
      endcase
`else
      if (accept) begin
        main_d = in_data;
        occ_d  = 2'd1;
      end else if (consume) begin
        occ_d = 2'd0;
      end
`endif
    end
  end

  always_comb begin
    bub_d = bub_q;
    if (out_ready && !out_valid && !flush && (bub_q != {CNT_W{1'b1}})) begin
      bub_d = bub_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      occ_q  <= 2'd0;
      main_q <= NOP_VAL;
      bub_q  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q <= NOP_VAL;
`endif
    end else begin
      en_q   <= en_d;
      occ_q  <= occ_d;
      main_q <= main_d;
      bub_q  <= bub_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q <= skid_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf; follows PIPE_STAGE_SKID_EN when defined.
module tb_pipe_stage_buf;

  localparam int unsigned DW = 160;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready, flush;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, in_ready4, out_valid4;
  logic [DW-1:0] out_data, out_data4;
  logic [1:0]    occupancy, occupancy4;
  logic [15:0]   bubble_cnt;
  logic [3:0]    bubble_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_buf dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_buf #(.DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .flush(flush),
    .occupancy(occupancy4), .bubble_cnt(bubble_cnt4)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    #1;
    chk("in_ready_during_rst", in_ready, 1'b0);
    tick();
    tick();
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_bub", bubble_cnt, 16'd0);

    // Bubble counting from reset: 5, then 20/15 (saturating 4-bit), then 23/15.
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("in_ready_after_rst", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("bub5", bubble_cnt, 16'd5);
    chk("bub5_data", out_data, '0);
    chk("bub5_valid", out_valid, 1'b0);
    chk("bub5_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    chk("bub20", bubble_cnt, 16'd20);
    chk("bub4_sat", bubble_cnt4, 4'd15);
    for (int i = 0; i < 3; i++) tick();
    chk("bub23", bubble_cnt, 16'd23);
    chk("bub4_hold", bubble_cnt4, 4'd15);

    // Single transfer after reset; first post-reset cycle must refuse it.
    rst = 1'b1;
    tick();
    chk("rst2_bub", bubble_cnt, 16'd0);
    chk("rst2_bub4", bubble_cnt4, 4'd0);
    rst = 1'b0; in_valid = 1'b1; in_data = DW'(8'hA5); out_ready = 1'b1;
    #1;
    chk("a5_blocked", in_ready, 1'b0);
    tick();
    chk("a5_not_taken", occupancy, 2'd0);
    tick();
    in_valid = 1'b0;
    chk("a5_valid", out_valid, 1'b1);
    chk("a5_data", out_data, DW'(8'hA5));
    chk("a5_occ", occupancy, 2'd1);
    tick();
    chk("a5_drain_occ", occupancy, 2'd0);
    chk("a5_drain_data", out_data, '0);
    chk("a5_bub", bubble_cnt, 16'd2);

    // Stall holds data; a second entry waits (or goes to skid); order preserved.
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(8'h11);
    tick();
    in_valid = 1'b0; in_data = DW'(8'h22);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", out_data, DW'(8'h11));
      chk("stall_valid", out_valid, 1'b1);
    end
    in_valid = 1'b1;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    chk("skid_in_ready", in_ready, 1'b1);
    tick();
    chk("skid_occ2", occupancy, 2'd2);
    chk("skid_full_ready", in_ready, 1'b0);
    chk("skid_head", out_data, DW'(8'h11));
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
`else
    chk("stall_in_ready", in_ready, 1'b0);
    tick();
    chk("stall_occ1", occupancy, 2'd1);
    chk("stall_head", out_data, DW'(8'h11));
    out_ready = 1'b1;
    #1;
    chk("pass_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
`endif
    chk("order_second", out_data, DW'(8'h22));
    chk("order_occ", occupancy, 2'd1);
    tick();
    chk("order_empty", occupancy, 2'd0);
    chk("order_bub", bubble_cnt, 16'd2);

    // Flush with a simultaneous offer: the offered entry must never appear.
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(8'h44);
    tick();
    in_data = DW'(8'h55);
    tick();
`ifdef PIPE_STAGE_SKID_EN
    chk("pre_flush_occ", occupancy, 2'd2);
`else
    chk("pre_flush_occ", occupancy, 2'd1);
`endif
    in_data = DW'(8'h33); flush = 1'b1;
    tick();
    chk("flush_occ", occupancy, 2'd0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_data", out_data, '0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("post_flush_valid", out_valid, 1'b0);
    chk("post_flush_bub", bubble_cnt, 16'd3);
    flush = 1'b1;
    tick();
    chk("flush_no_bub", bubble_cnt, 16'd3);
    flush = 1'b0;

    // Reset overrides flush and transfers while full.
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(8'h66);
    tick();
    in_data = DW'(8'h77);
    tick();
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("rst3_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0; flush = 1'b0;
    #1;
    chk("rst3_occ", occupancy, 2'd0);
    chk("rst3_bub", bubble_cnt, 16'd0);
    chk("rst3_in_ready_after", in_ready, 1'b0);
    chk("rst3_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
